// File: rtl/div32_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
// State encodings are fixed so that they read the same on a logic analyser.
package div32_seq_pkg;

    localparam int DATA_W     = 32;
    localparam int ITER_COUNT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/div32_seq_if.sv
// Request/result bundle between an ALU issue stage and the divider.
interface div32_seq_if
    import div32_seq_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, is_signed, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, is_signed, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/div32_seq_restore_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, try a subtract,
// keep it only when the partial remainder stays non-negative.
module div32_seq_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             din,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;

    assign shifted = {rem, din};
    // Compare at WIDTH+1 bits; when it succeeds the difference is below dvs,
    // so a WIDTH-bit subtract is exact.
    assign q_bit    = (shifted >= {1'b0, dvs});
    assign rem_next = q_bit ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
endmodule

// File: rtl/div32_seq.sv
// Sequential signed/unsigned divider, one quotient bit per clock.
// HI = remainder, LO = quotient, mirroring the multiplier result pair.
module div32_seq
    import div32_seq_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic        clk,
    input  logic        rst,
    div32_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(ITER_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [WIDTH-1:0] dvs_reg, dvs_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic             sgn_a_reg, sgn_a_next;
    logic             sgn_b_reg, sgn_b_next;
    logic             dz_reg, dz_next;

    logic             in_sgn_a, in_sgn_b;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    // Magnitudes are unsigned, so |0x80000000| = 0x80000000 is exact.
    assign in_sgn_a = bus.is_signed & bus.a[WIDTH-1];
    assign in_sgn_b = bus.is_signed & bus.b[WIDTH-1];
    assign a_mag    = in_sgn_a ? (~bus.a + 1'b1) : bus.a;
    assign b_mag    = in_sgn_b ? (~bus.b + 1'b1) : bus.b;

    // Truncation toward zero: remainder follows the dividend's sign.
    assign quo_fix  = (sgn_a_reg ^ sgn_b_reg) ? (~quo_reg + 1'b1) : quo_reg;
    assign rem_fix  = sgn_a_reg ? (~rem_reg + 1'b1) : rem_reg;

    div32_seq_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_reg),
        .din      (quo_reg[WIDTH-1]),
        .dvs      (dvs_reg),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rem_next   = rem_reg;
        quo_next   = quo_reg;
        dvs_next   = dvs_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        sgn_a_next = sgn_a_reg;
        sgn_b_next = sgn_b_reg;
        dz_next    = dz_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    sgn_a_next = in_sgn_a;
                    sgn_b_next = in_sgn_b;
                    quo_next   = a_mag;
                    dvs_next   = b_mag;
                    rem_next   = '0;
                    cnt_next   = '0;
                    dz_next    = (bus.b == '0);
                    if (bus.b == '0) begin
                        hi_next    = bus.a;
                        lo_next    = '1;
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_next = step_rem;
                quo_next = {quo_reg[WIDTH-2:0], step_q};
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                lo_next    = quo_fix;
                hi_next    = rem_fix;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvs_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            sgn_a_reg <= 1'b0;
            sgn_b_reg <= 1'b0;
            dz_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rem_reg   <= rem_next;
            quo_reg   <= quo_next;
            dvs_reg   <= dvs_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            sgn_a_reg <= sgn_a_next;
            sgn_b_reg <= sgn_b_next;
            dz_reg    <= dz_next;
        end
    end

    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    assign bus.div_zero = dz_reg;
    assign bus.busy     = (state_reg == ST_CALC) || (state_reg == ST_FIX);
    assign bus.done     = (state_reg == ST_DONE);
endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq: stimulus pushes expected results, a monitor
// pops and compares on every DONE pulse.
module tb_div32_seq;
    logic clk;
    logic rst;

    div32_seq_if #(.WIDTH(32)) bus ();

    div32_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    n_txn++;
                    $display("txn %0d: hi=0x%08h lo=0x%08h dz=%0b (exp hi=0x%08h lo=0x%08h dz=%0b)",
                             n_txn, bus.hi, bus.lo, bus.div_zero, e.hi, e.lo, e.dz);
                    check("hi", bus.hi, e.hi);
                    check("lo", bus.lo, e.lo);
                    check("div_zero", {31'd0, bus.div_zero}, {31'd0, e.dz});
                end
            end
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                         input bit inject);
        exp_t e;
        int   lat;
        int   busy_cnt;
        bit   got;
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.is_signed = sgn;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.a         = 32'hDEAD_BEEF;
        bus.b         = 32'h0000_0000;
        bus.is_signed = ~sgn;
        lat = 0;
        busy_cnt = 0;
        got = 1'b0;
        for (int n = 1; n <= 100 && !got; n++) begin
            @(negedge clk);
            if (inject && n == 5) begin
                bus.start     = 1'b1;
                bus.a         = 32'd1;
                bus.b         = 32'd0;
                bus.is_signed = 1'b0;
            end else if (inject && n == 6) begin
                bus.start = 1'b0;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                lat = n;
                got = 1'b1;
            end
        end
        check("done_latency", lat, edz ? 32'd1 : 32'd34);
        check("busy_cycles", busy_cnt, edz ? 32'd0 : 32'd33);
        @(negedge clk);
        check("done_pulse_width", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(negedge clk);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_dz", {31'd0, bus.div_zero}, 32'd0);
        rst = 1'b0;

        do_op(32'd100,       32'd7,         1'b0, 32'd2,         32'd14,        1'b0, 1'b0);
        do_op(32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        do_op(32'd7,         32'hFFFF_FFFE, 1'b1, 32'd1,         32'hFFFF_FFFD, 1'b0, 1'b0);
        do_op(32'hFFFF_FFF9, 32'd2,         1'b0, 32'd1,         32'h7FFF_FFFC, 1'b0, 1'b0);
        do_op(32'd5,         32'd0,         1'b0, 32'd5,         32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0,         32'h8000_0000, 1'b0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFFE, 32'd14,        1'b0, 1'b0);
        do_op(32'd1000,      32'd10,        1'b0, 32'd0,         32'd100,       1'b0, 1'b1);
        do_op(32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Abort an operation mid-flight; no result is expected from it.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.a         = 32'd50;
        bus.b         = 32'd4;
        bus.is_signed = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_dz", {31'd0, bus.div_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(32'd9, 32'd3, 1'b1, 32'd0, 32'd3, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div32_seq.md
Name: div32_seq

Overview:
- Sequential 32-bit integer divider; the inverse of the combinational MULT32/MULT32_U multiplier path in the ALU.
- Radix-2 restoring algorithm: one quotient bit per clock, signed or unsigned, multi-cycle with a START/BUSY/DONE handshake.
- Output convention matches the multiplier pair: HI = remainder, LO = quotient. Sits beside the multiplier in the ALU for DIV/DIVU operations.

Parameters:
- WIDTH, 32, operand/result width; only 32 is verified.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- START  in  1  request; sampled only in IDLE.
- SIGNED  in  1  1 = two's-complement divide, 0 = unsigned; sampled with START.
- A  in  WIDTH  dividend; sampled with START.
- B  in  WIDTH  divisor; sampled with START.
- HI  out  WIDTH  remainder.
- LO  out  WIDTH  quotient.
- BUSY  out  1  high in CALC and FIX.
- DONE  out  1  one-cycle pulse; HI/LO/DIV_ZERO valid from this cycle.
- DIV_ZERO  out  1  B was 0 for the completed operation; valid with DONE and held until the next accept.

Behaviour:
- Reset, at any time including mid-operation:
  - state = IDLE.
  - HI, LO, BUSY, DONE, DIV_ZERO = 0.
  - Internal counter and working registers = 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - START=1 at edge e0 latches SIGNED, the sign flags of A and B, |A| and |B| (magnitudes only when SIGNED=1), and clears the partial remainder and counter.
  - Next state is CALC, or DONE if B==0.
- CALC: edges e1..e32, one iteration per edge:
  - Shift {R,Q} left 1, bringing in the next dividend bit.
  - Trial = R − |B| at WIDTH+1 bits.
  - If trial is non-negative: R = trial, Q bit = 1. Otherwise R is restored, Q bit = 0.
  - Counter increments; after iteration 32 the next state is FIX.
- FIX (edge e33):
  - If SIGNED and sign(A) XOR sign(B): LO = −Q, else LO = Q.
  - If SIGNED and sign(A): HI = −R, else HI = R.
  - Division truncates toward zero; the remainder takes the dividend's sign.
  - Next state is DONE.
- DONE: DONE=1 for exactly one cycle, then IDLE.
- Latency: DONE is high in the cycle after e33, i.e. 33 cycles after the accepting edge. Divide-by-zero is 1 cycle.
- Divide by zero:
  - At e0: LO = all ones, HI = A (raw, unconverted), DIV_ZERO = 1.
  - Goes straight to DONE; the SIGNED value is irrelevant.
- Signed overflow: 0x80000000 / −1 needs no special case. The magnitude quotient 2^31 negates to LO = 0x80000000, HI = 0.
- Negation of |A| = 2^31 is carried in WIDTH+1 bits internally so it is lossless.
- HI/LO hold their previous result throughout CALC; they update only at FIX or at the div-zero accept.
- START while in CALC, FIX or DONE is ignored: no queueing, no effect on the operation in flight.
- DIV_ZERO clears on the next accepted START.
- A, B and SIGNED may change freely after the accepting edge.
- Back-to-back operations: START held high continuously is re-accepted at the first edge spent in IDLE.

Decomposition:
- Shared defines (prj_definition.v):
  - Data width.
  - 2-bit state encodings: IDLE=00, CALC=01, FIX=10, DONE=11.
  - Iteration count constant (32).
- Sub-module: div_restore_step, combinational.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: next remainder, quotient bit.
  - Built on RC_ADD_SUB_32 in subtract mode.
- Top-level:
  - Conditional negation reuses TWOSCOMP32 with MUX32_2x1.
  - FSM, counter and registers are in the top level.

Test Plan:
- Unsigned 100 / 7, SIGNED=0:
  - LO = 14, HI = 2, DIV_ZERO = 0.
  - DONE exactly 33 cycles after the accept edge; BUSY high for 33 cycles.
- Signed mixed-sign divides:
  - −7 / 2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - 7 / −2: LO = 0xFFFFFFFD, HI = 1.
  - Same −7 / 2 inputs with SIGNED=0: LO = 0x7FFFFFFC, HI = 1.
- Divide by zero, 5 / 0:
  - DONE on the cycle after accept.
  - LO = 0xFFFFFFFF, HI = 5, DIV_ZERO = 1.
  - Next valid divide clears DIV_ZERO.
- Signed extremes:
  - 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Unsigned 0xFFFFFFFF / 1: LO = 0xFFFFFFFF, HI = 0.
- START pulsed at cycle 5 of CALC with new operands: ignored, and the first result is unchanged.
- RST asserted at cycle 10 of CALC:
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, a new 9 / 3 gives LO = 3, HI = 0.
